// File: rtl/sdram_cmd_pkg.sv
// Shared definitions for the SDRAM command sequencer: pin encodings,
// FSM states and the helper that sizes the wait counter.
package sdram_cmd_pkg;

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;
    localparam logic [3:0] CMD_DESL = 4'b1111;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT,
        S_RCD_WAIT,
        S_RW,
        S_DATA,
        S_PRE,
        S_REF,
        S_LMR,
        S_WAIT
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Cycles from RD/WR on pins until IDLE for a write / read burst.
    function automatic int wr_len(input int t_wr, input int t_rp, input int burst);
        return burst + t_wr + t_rp;
    endfunction

    function automatic int rd_len(input int t_rp, input int cas, input int burst);
        return max2(burst, cas + burst - 1) + t_rp;
    endfunction

    // Largest span any wait ever has to cover.
    function automatic int max_wait(input int t_rcd, input int t_rp, input int t_rfc,
                                    input int t_mrd, input int t_wr, input int cas,
                                    input int burst);
        int m;
        m = max2(wr_len(t_wr, t_rp, burst), rd_len(t_rp, cas, burst));
        m = max2(m, max2(t_rcd, t_rp));
        m = max2(m, max2(t_rfc, t_mrd));
        return m;
    endfunction

endpackage

// File: rtl/sdram_command_sequencer_if.sv
// Host-side handshake between the control interface and the command sequencer.
interface sdram_command_sequencer_if #(
    parameter int ASIZE = 22
);
    logic             nop;
    logic             reada;
    logic             writea;
    logic             refresh;
    logic             precharge;
    logic             load_mode;
    logic [ASIZE-1:0] saddr;
    logic             ref_req;
    logic             init_req;
    logic             cm_ack;
    logic             ref_ack;
    logic             init_ack;

    modport master (
        output nop, reada, writea, refresh, precharge, load_mode, saddr, ref_req, init_req,
        input  cm_ack, ref_ack, init_ack
    );

    modport slave (
        input  nop, reada, writea, refresh, precharge, load_mode, saddr, ref_req, init_req,
        output cm_ack, ref_ack, init_ack
    );
endinterface

// File: rtl/sdram_wait_timer.sv
// Loadable down-counter that saturates at zero; done while the count is zero.
module sdram_wait_timer
    import sdram_cmd_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_value;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sdram_command_sequencer.sv
// SDRAM command sequencer: arbitrates init/refresh/host requests and drives
// the SDRAM command pins with the ACT/RD/WR/PRE/REF/LMR timing. All pins and
// handshakes come straight from registers.
module sdram_command_sequencer
    import sdram_cmd_pkg::*;
#(
    parameter int ASIZE    = 22,
    parameter int BANKSIZE = 2,
    parameter int ROWSIZE  = 12,
    parameter int COLSIZE  = 8,
    parameter int T_RCD    = 2,
    parameter int T_RP     = 2,
    parameter int T_RFC    = 7,
    parameter int T_MRD    = 2,
    parameter int T_WR     = 2,
    parameter int CAS_LAT  = 2,
    parameter int BURST    = 4,
    parameter logic [ROWSIZE-1:0] MODE_REG = 12'h022
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    sdram_command_sequencer_if.slave host,
    output logic                    o_cke,
    output logic                    o_cs_n,
    output logic                    o_ras_n,
    output logic                    o_cas_n,
    output logic                    o_we_n,
    output logic [BANKSIZE-1:0]     o_ba,
    output logic [ROWSIZE-1:0]      o_sa,
    output logic                    o_oe,
    output logic                    o_rd_valid
);

    localparam int TW     = $clog2(max_wait(T_RCD, T_RP, T_RFC, T_MRD, T_WR, CAS_LAT, BURST)) + 1;
    localparam int AP_BIT = 10;

    // Timer preloads: a state that loads N leaves its wait state N+1 cycles
    // later, so every span is preloaded with (span - 2).
    localparam logic [TW-1:0] LD_RCD = TW'(T_RCD - 2);
    localparam logic [TW-1:0] LD_RP  = TW'(T_RP - 2);
    localparam logic [TW-1:0] LD_RFC = TW'(T_RFC - 2);
    localparam logic [TW-1:0] LD_MRD = TW'(T_MRD - 2);
    localparam logic [TW-1:0] LD_WR  = TW'(wr_len(T_WR, T_RP, BURST) - 2);
    localparam logic [TW-1:0] LD_RD  = TW'(rd_len(T_RP, CAS_LAT, BURST) - 2);

    // Beat boundaries, counted from the RD/WR cycle (beat 0).
    localparam logic [TW-1:0] B_BURST  = TW'(BURST);
    localparam logic [TW-1:0] B_RD_BEG = TW'(CAS_LAT);
    localparam logic [TW-1:0] B_RD_END = TW'(CAS_LAT + BURST);

    state_t               r_state;
    logic                 r_cke;
    logic [3:0]           r_cmd;
    logic [BANKSIZE-1:0]  r_ba;
    logic [ROWSIZE-1:0]   r_sa;
    logic                 r_cm_ack, r_ref_ack, r_init_ack;
    logic                 r_oe, r_rd_valid;
    logic                 r_pre_pend, r_ref_pend, r_lmr_pend;
    logic                 r_rearm;
    logic                 r_is_wr;
    logic [COLSIZE-1:0]   r_col;
    logic [TW-1:0]        r_beat;

    logic [BANKSIZE-1:0]  w_bank;
    logic [ROWSIZE-1:0]   w_row;
    logic [COLSIZE-1:0]   w_col;
    logic [ROWSIZE-1:0]   w_sa_rw;
    logic [ROWSIZE-1:0]   w_sa_pre;
    logic [TW-1:0]        w_beat_nxt;
    logic                 w_host_req;
    logic                 w_load;
    logic [TW-1:0]        w_value;
    logic                 w_done;

    assign w_bank     = host.saddr[ASIZE-1 -: BANKSIZE];
    assign w_row      = host.saddr[ASIZE-BANKSIZE-1 -: ROWSIZE];
    assign w_col      = host.saddr[COLSIZE-1:0];
    assign w_beat_nxt = r_beat + 1'b1;
    assign w_host_req = (host.reada | host.writea) & ~host.nop & ~host.init_req & r_rearm;

    // Column address with auto-precharge, and the precharge-all address.
    always_comb begin
        w_sa_rw                 = '0;
        w_sa_rw[COLSIZE-1:0]    = r_col;
        w_sa_rw[AP_BIT]         = 1'b1;
        w_sa_pre                = '0;
        w_sa_pre[AP_BIT]        = 1'b1;
    end

    // Each command state arms the shared timer for the wait that follows it.
    always_comb begin
        w_load  = 1'b0;
        w_value = '0;
        case (r_state)
            S_ACT:   begin w_load = 1'b1; w_value = LD_RCD; end
            S_RW:    begin w_load = 1'b1; w_value = r_is_wr ? LD_WR : LD_RD; end
            S_PRE:   begin w_load = 1'b1; w_value = LD_RP;  end
            S_REF:   begin w_load = 1'b1; w_value = LD_RFC; end
            S_LMR:   begin w_load = 1'b1; w_value = LD_MRD; end
            default: ;
        endcase
    end

    sdram_wait_timer #(.W(TW)) u_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_value (w_value),
        .o_done  (w_done)
    );

    // Main sequencer: pending-flag capture, re-arm tracking, arbitration and pin drive.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cke      <= 1'b0;
            r_cmd      <= CMD_DESL;
            r_ba       <= '0;
            r_sa       <= '0;
            r_cm_ack   <= 1'b0;
            r_ref_ack  <= 1'b0;
            r_init_ack <= 1'b0;
            r_oe       <= 1'b0;
            r_rd_valid <= 1'b0;
            r_pre_pend <= 1'b0;
            r_ref_pend <= 1'b0;
            r_lmr_pend <= 1'b0;
            r_rearm    <= 1'b0;
            r_is_wr    <= 1'b0;
            r_col      <= '0;
            r_beat     <= '0;
        end else begin
            r_cke      <= 1'b1;
            r_cmd      <= CMD_NOP;
            r_cm_ack   <= 1'b0;
            r_ref_ack  <= 1'b0;
            r_init_ack <= 1'b0;
            r_oe       <= 1'b0;
            r_rd_valid <= 1'b0;
            // Sticky capture; an issuing branch below overrides with a clear,
            // so a pulse coinciding with its own command is absorbed by it.
            r_pre_pend <= r_pre_pend | host.precharge;
            r_ref_pend <= r_ref_pend | host.refresh;
            r_lmr_pend <= r_lmr_pend | host.load_mode;
            // A held READA/WRITEA must drop for a cycle before it can issue again.
            if (r_cm_ack)
                r_rearm <= 1'b0;
            else if (!host.reada && !host.writea)
                r_rearm <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (r_pre_pend) begin
                        r_cmd      <= CMD_PRE;
                        r_ba       <= '0;
                        r_sa       <= w_sa_pre;
                        r_pre_pend <= 1'b0;
                        r_state    <= S_PRE;
                    end else if (r_ref_pend || host.ref_req) begin
                        r_cmd      <= CMD_REF;
                        r_ba       <= '0;
                        r_sa       <= '0;
                        r_ref_ack  <= host.ref_req;
                        r_ref_pend <= 1'b0;
                        r_state    <= S_REF;
                    end else if (r_lmr_pend) begin
                        r_cmd      <= CMD_LMR;
                        r_ba       <= '0;
                        r_sa       <= MODE_REG;
                        r_init_ack <= 1'b1;
                        r_lmr_pend <= 1'b0;
                        r_state    <= S_LMR;
                    end else if (w_host_req) begin
                        r_cmd      <= CMD_ACT;
                        r_ba       <= w_bank;
                        r_sa       <= w_row;
                        r_is_wr    <= ~host.reada;
                        r_col      <= w_col;
                        r_state    <= S_ACT;
                    end
                end
                S_ACT: r_state <= S_RCD_WAIT;
                S_RCD_WAIT: begin
                    if (w_done) begin
                        r_cmd    <= r_is_wr ? CMD_WR : CMD_RD;
                        r_sa     <= w_sa_rw;
                        r_cm_ack <= 1'b1;
                        r_oe     <= r_is_wr;
                        r_beat   <= '0;
                        r_state  <= S_RW;
                    end
                end
                S_RW, S_DATA: begin
                    r_beat     <= w_beat_nxt;
                    r_oe       <= r_is_wr && (w_beat_nxt < B_BURST);
                    r_rd_valid <= !r_is_wr && (w_beat_nxt >= B_RD_BEG) && (w_beat_nxt < B_RD_END);
                    // In S_RW the timer is only now being loaded, so done is stale.
                    r_state    <= (r_state == S_DATA && w_done) ? S_IDLE : S_DATA;
                end
                S_PRE, S_REF, S_LMR: r_state <= S_WAIT;
                S_WAIT: if (w_done) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cke                              = r_cke;
    assign {o_cs_n, o_ras_n, o_cas_n, o_we_n} = r_cmd;
    assign o_ba                               = r_ba;
    assign o_sa                               = r_sa;
    assign o_oe                               = r_oe;
    assign o_rd_valid                         = r_rd_valid;
    assign host.cm_ack                        = r_cm_ack;
    assign host.ref_ack                       = r_ref_ack;
    assign host.init_ack                      = r_init_ack;

endmodule

// File: tb/tb_sdram_command_sequencer.sv
// Scoreboard bench for the SDRAM command sequencer: directed stimulus pushes
// the expected command / data-strobe stream, a negedge monitor pops and compares.
module tb_sdram_command_sequencer;

    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_REF  = 4'b0001;
    localparam logic [3:0] C_LMR  = 4'b0000;
    localparam logic [3:0] C_DESL = 4'b1111;

    // ack = {cm_ack, ref_ack, init_ack}; gap = cycles since previous command, -1 = any
    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [11:0] sa;
        logic [2:0]  ack;
        int          gap;
    } exp_t;

    // off = cycles since the last RD/WR command
    typedef struct {
        logic oe;
        logic rdv;
        int   off;
    } stb_t;

    exp_t exp_q[$];
    stb_t stb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   last_rw = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cke, cs_n, ras_n, cas_n, we_n, oe, rdv;
    logic [1:0]  ba;
    logic [11:0] sa;
    logic [3:0]  pins;

    sdram_command_sequencer_if #(.ASIZE(22)) hif ();

    sdram_command_sequencer dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .host       (hif),
        .o_cke      (cke),
        .o_cs_n     (cs_n),
        .o_ras_n    (ras_n),
        .o_cas_n    (cas_n),
        .o_we_n     (we_n),
        .o_ba       (ba),
        .o_sa       (sa),
        .o_oe       (oe),
        .o_rd_valid (rdv)
    );

    always #5 clk = ~clk;
    assign pins = {cs_n, ras_n, cas_n, we_n};

    // Monitor: every issued command and every data strobe is matched in order.
    always @(negedge clk) begin
        exp_t       e;
        stb_t       s;
        logic [2:0] ak;
        int         gap;
        cyc++;
        ak = {hif.cm_ack, hif.ref_ack, hif.init_ack};
        if (pins != C_NOP && pins != C_DESL) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL cmd_unexpected cyc=%0d got cmd=%b ba=%0d sa=%h ack=%b, need no command",
                         cyc, pins, ba, sa, ak);
            end else begin
                e   = exp_q.pop_front();
                gap = cyc - last_cyc;
                if (pins !== e.cmd || ba !== e.ba || sa !== e.sa || ak !== e.ack ||
                    (e.gap >= 0 && gap != e.gap)) begin
                    n_err++;
                    $display("FAIL cmd_seq cyc=%0d got cmd=%b ba=%0d sa=%h ack=%b gap=%0d, need cmd=%b ba=%0d sa=%h ack=%b gap=%0d",
                             cyc, pins, ba, sa, ak, gap, e.cmd, e.ba, e.sa, e.ack, e.gap);
                end
            end
            last_cyc = cyc;
            if (pins == C_RD || pins == C_WR) last_rw = cyc;
        end else if (ak != 3'b000) begin
            n_cmp++;
            n_err++;
            $display("FAIL ack_unexpected cyc=%0d got ack=%b on cmd=%b, need 000", cyc, ak, pins);
        end
        if (oe || rdv) begin
            n_cmp++;
            if (stb_q.size() == 0) begin
                n_err++;
                $display("FAIL strobe_unexpected cyc=%0d got oe=%b rd_valid=%b, need none", cyc, oe, rdv);
            end else begin
                s = stb_q.pop_front();
                if (oe !== s.oe || rdv !== s.rdv || (cyc - last_rw) != s.off) begin
                    n_err++;
                    $display("FAIL strobe cyc=%0d got oe=%b rd_valid=%b off=%0d, need oe=%b rd_valid=%b off=%0d",
                             cyc, oe, rdv, cyc - last_rw, s.oe, s.rdv, s.off);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h need=%h", nm, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a,
                            input logic [2:0] k, input int g);
        exp_t e;
        e.cmd = c; e.ba = b; e.sa = a; e.ack = k; e.gap = g;
        exp_q.push_back(e);
    endtask

    task automatic push_stb(input logic is_wr);
        stb_t s;
        for (int k = 0; k < 4; k++) begin
            s.oe  = is_wr;
            s.rdv = !is_wr;
            s.off = is_wr ? k : k + 2;
            stb_q.push_back(s);
        end
    endtask

    // sel: 0 cm_ack, 1 ref_ack, 2 ACT on pins
    task automatic wait_sig(input int sel, input int lim, input string nm);
        for (int i = 0; i < lim; i++) begin
            @(posedge clk);
            #1;
            if ((sel == 0 && hif.cm_ack) || (sel == 1 && hif.ref_ack) || (sel == 2 && pins == C_ACT))
                return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL %s timeout got no event in %0d cycles, need event", nm, lim);
    endtask

    // sel: 0 PRECHARGE, 1 REFRESH, 2 LOAD_MODE; one-cycle pulse then 19 idle cycles
    task automatic pulse(input int sel);
        hif.precharge = (sel == 0);
        hif.refresh   = (sel == 1);
        hif.load_mode = (sel == 2);
        tick(1);
        hif.precharge = 1'b0;
        hif.refresh   = 1'b0;
        hif.load_mode = 1'b0;
        tick(19);
    endtask

    task automatic host_req(input logic rd, input logic wr);
        hif.reada  = rd;
        hif.writea = wr;
        hif.nop    = !(rd | wr);
    endtask

    initial begin
        host_req(1'b0, 1'b0);
        hif.refresh   = 1'b0;
        hif.precharge = 1'b0;
        hif.load_mode = 1'b0;
        hif.saddr     = '0;
        hif.ref_req   = 1'b0;
        hif.init_req  = 1'b0;

        // Reset state
        tick(3);
        chk("rst_cke", 32'(cke), 0);
        chk("rst_pins", 32'(pins), 32'(C_DESL));
        chk("rst_ba_sa", {18'd0, ba, sa}, 0);
        chk("rst_strobes_acks", {27'd0, oe, rdv, hif.cm_ack, hif.ref_ack, hif.init_ack}, 0);
        rst = 1'b0;
        tick(1);
        chk("cke_after_reset", 32'(cke), 1);
        chk("pins_idle_nop", 32'(pins), 32'(C_NOP));
        tick(3);

        // 1: init sequence, REF pulses give no REF_ACK
        hif.init_req = 1'b1;
        push_cmd(C_PRE, 2'd0, 12'h400, 3'b000, -1);
        pulse(0);
        for (int i = 0; i < 8; i++) begin
            push_cmd(C_REF, 2'd0, 12'h000, 3'b000, 20);
            pulse(1);
        end
        push_cmd(C_LMR, 2'd0, 12'h022, 3'b001, 20);
        pulse(2);
        hif.init_req = 1'b0;
        tick(2);

        // 2: read 22'h2ABC12
        hif.saddr = 22'h2ABC12;
        push_cmd(C_ACT, 2'd2, 12'hABC, 3'b000, -1);
        push_cmd(C_RD,  2'd2, 12'h412, 3'b100, 2);
        push_stb(1'b0);
        host_req(1'b1, 1'b0);
        wait_sig(0, 30, "read_cm_ack");
        host_req(1'b0, 1'b0);
        tick(15);

        // 3: write held 40 cycles issues once; drop 1 cycle and reassert for a second
        hif.saddr = 22'h15A37F;
        push_cmd(C_ACT, 2'd1, 12'h5A3, 3'b000, -1);
        push_cmd(C_WR,  2'd1, 12'h47F, 3'b100, 2);
        push_stb(1'b1);
        host_req(1'b0, 1'b1);
        tick(40);
        host_req(1'b0, 1'b0);
        tick(1);
        push_cmd(C_ACT, 2'd1, 12'h5A3, 3'b000, -1);
        push_cmd(C_WR,  2'd1, 12'h47F, 3'b100, 2);
        push_stb(1'b1);
        host_req(1'b0, 1'b1);
        wait_sig(0, 30, "write2_cm_ack");
        host_req(1'b0, 1'b0);
        tick(15);

        // 4: REF_REQ rises on the ACT cycle; write finishes, then REF with REF_ACK
        hif.saddr = 22'h3C0155;
        push_cmd(C_ACT, 2'd3, 12'hC01, 3'b000, -1);
        push_cmd(C_WR,  2'd3, 12'h455, 3'b100, 2);
        push_stb(1'b1);
        push_cmd(C_REF, 2'd0, 12'h000, 3'b010, 9);
        host_req(1'b0, 1'b1);
        wait_sig(2, 20, "ref_req_act");
        hif.ref_req = 1'b1;
        wait_sig(0, 20, "ref_req_cm_ack");
        host_req(1'b0, 1'b0);
        wait_sig(1, 30, "ref_req_ref_ack");
        hif.ref_req = 1'b0;
        tick(12);

        // 5: reset in the DATA phase of a read aborts it
        hif.saddr = 22'h3FFFFF;
        push_cmd(C_ACT, 2'd3, 12'hFFF, 3'b000, -1);
        push_cmd(C_RD,  2'd3, 12'h4FF, 3'b100, 2);
        host_req(1'b1, 1'b0);
        wait_sig(0, 30, "abort_cm_ack");
        host_req(1'b0, 1'b0);
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("abort_pins", 32'(pins), 32'(C_DESL));
        chk("abort_cke", 32'(cke), 0);
        chk("abort_rd_valid", 32'(rdv), 0);
        tick(1);
        rst = 1'b0;
        tick(10);

        // 6: READA blocked by INIT_REQ, issues one cycle after it falls
        hif.saddr    = 22'h000001;
        hif.init_req = 1'b1;
        host_req(1'b1, 1'b0);
        tick(10);
        push_cmd(C_ACT, 2'd0, 12'h000, 3'b000, -1);
        push_cmd(C_RD,  2'd0, 12'h401, 3'b100, 2);
        push_stb(1'b0);
        hif.init_req = 1'b0;
        tick(1);
        chk("init_release_act", 32'(pins), 32'(C_ACT));
        wait_sig(0, 20, "init_release_cm_ack");
        host_req(1'b0, 1'b0);
        tick(12);

        // 7: REFRESH pulse together with REF_REQ gives a single REF with REF_ACK
        push_cmd(C_REF, 2'd0, 12'h000, 3'b010, -1);
        hif.refresh = 1'b1;
        hif.ref_req = 1'b1;
        tick(1);
        hif.refresh = 1'b0;
        if (!hif.ref_ack) wait_sig(1, 20, "ref_merge_ack");
        hif.ref_req = 1'b0;
        tick(20);

        chk("exp_q_drained", 32'(exp_q.size()), 0);
        chk("stb_q_drained", 32'(stb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
